// File: rtl/tree_adder_packer.sv
// Packs DW-bit samples, 2**N per frame (lane 0 at LSBs), into a registered frame for the tree adder.
// Optional early frame close on s_last when TREE_PACK_FLUSH_EN is defined.
module tree_adder_packer #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DW-1:0]         s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [(2**N)*DW-1:0]  m_data,
  output logic [N:0]            m_count
);

  localparam int            LANES   = 2**N;
  localparam int            FW      = LANES * DW;
  localparam logic [N-1:0]  IDX_MAX = '1;

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [FW-1:0]   coll_q, coll_d;
  logic [FW-1:0]   m_data_q, m_data_d;
  logic [N:0]      m_count_q, m_count_d;
  logic            m_valid_q, m_valid_d;
  logic            s_ready_q, s_ready_d;

  logic            accept;
  logic            complete;
  logic            out_free;
  logic [FW-1:0]   frame_w;
  logic [N:0]      fill_cnt;

  // s_ready_q resets to 1 (COLLECT) and is masked by rst, so it reads 0 during
  // reset and 1 immediately after release.
  assign s_ready  = s_ready_q & ~rst;
  assign accept   = s_valid & s_ready;
  assign out_free = ~m_valid_q | m_ready;
  assign fill_cnt = {1'b0, idx_q} + (N+1)'(1);

`ifdef TREE_PACK_FLUSH_EN
  assign complete = accept & ((idx_q == IDX_MAX) | s_last);
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign complete      = accept & (idx_q == IDX_MAX);
`endif

  always_comb begin
    frame_w = coll_q;
    frame_w[int'(idx_q)*DW +: DW] = s_data;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    coll_d    = coll_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_count_d = m_count_q;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (complete && out_free) begin
            m_data_d  = frame_w;
            m_count_d = fill_cnt;
            m_valid_d = 1'b1;
            coll_d    = '0;
            idx_d     = '0;
          end else if (complete) begin
            // idx stays on the closing lane so fill_cnt is still valid in HOLD
            coll_d  = frame_w;
            state_d = HOLD;
          end else begin
            coll_d = frame_w;
            idx_d  = idx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          m_data_d  = coll_q;
          m_count_d = fill_cnt;
          m_valid_d = 1'b1;
          coll_d    = '0;
          idx_d     = '0;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    s_ready_d = (state_d == COLLECT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      // NOTE: the collector is a datapath register that is still reset, because
      // unfilled lanes of a short frame must read as zero.
      coll_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_count_q <= '0;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      coll_q    <= coll_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_count_q <= m_count_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_count = m_count_q;

endmodule

// File: tb/tb_tree_adder_packer.sv
// Directed bench for tree_adder_packer (N=4, DW=8) with a frame scoreboard.
// Expectations follow the flush behaviour selected by TREE_PACK_FLUSH_EN.
module tb_tree_adder_packer;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int LANES = 16;
  localparam int FW    = LANES * DW;
`ifdef TREE_PACK_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid;
  logic           s_ready;
  logic [DW-1:0]  s_data;
  logic           s_last;
  logic           m_valid;
  logic           m_ready;
  logic [FW-1:0]  m_data;
  logic [N:0]     m_count;

  tree_adder_packer #(.N(N), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_count (m_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FW-1:0] data;
    logic [N:0]    cnt;
  } frame_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  int            stalls = 0;
  frame_t        sb_q[$];
  int            take_q[$];
  logic [FW-1:0] model_coll;
  int            model_idx;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk_frame(input int base, input int cnt);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < cnt; k++) f[k*DW +: DW] = DW'(base + k);
    return f;
  endfunction

  task automatic model_accept(input logic [DW-1:0] d, input logic last);
    frame_t f;
    model_coll[model_idx*DW +: DW] = d;
    if (model_idx == LANES-1 || (FLUSH && last)) begin
      f.data = model_coll;
      f.cnt  = (N+1)'(model_idx + 1);
      sb_q.push_back(f);
      model_coll = '0;
      model_idx  = 0;
    end else begin
      model_idx++;
    end
  endtask

  // Offer one sample; inputs change 1 time unit after the rising edge.
  task automatic send(input logic [DW-1:0] d, input logic last);
    int waited;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    while (s_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    stalls += waited;
    if (s_ready !== 1'b1) check("send_timeout", s_ready, 1'b1);
    else model_accept(d, last);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard: every handshake observed must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
      frame_t f;
      take_q.push_back(cyc);
      check("sb_has_frame", FW'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        f = sb_q.pop_front();
        check("sb_data", m_data, f.data);
        check("sb_count", m_count, f.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    m_ready    = 1'b0;
    model_coll = '0;
    model_idx  = 0;

    // Reset state
    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, '0);
    check("rst_m_count", m_count, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1'b1);

    // Single frame 1..16, latency and valid drop
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) send(DW'(i), 1'b0);
    @(negedge clk);
    check("t1_m_valid", m_valid, 1'b1);
    check("t1_m_data", m_data, 128'h100F0E0D0C0B0A090807060504030201);
    check("t1_m_count", m_count, 5'd16);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_valid_drop", m_valid, 1'b0);

    // 48 continuous samples: three frames, no stall, 16-cycle spacing
    idle(2);
    take_q.delete();
    stalls = 0;
    for (int i = 0; i < 48; i++) send(DW'(8'h60 + i), 1'b0);
    idle(3);
    check("t2_no_stall", stalls, 0);
    check("t2_frames", take_q.size(), 3);
    if (take_q.size() == 3) begin
      check("t2_spacing_a", take_q[1] - take_q[0], 16);
      check("t2_spacing_b", take_q[2] - take_q[1], 16);
    end

    // s_last behaviour
    for (int i = 0; i < 4; i++) send(DW'(8'hA1 + i), 1'b0);
    send(8'hA5, 1'b1);
    @(negedge clk);
`ifdef TREE_PACK_FLUSH_EN
    check("fl_m_valid", m_valid, 1'b1);
    check("fl_m_count", m_count, 5'd5);
    check("fl_m_data", m_data, mk_frame(8'hA1, 5));
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) send(DW'(8'hB0 + i), 1'b0);
    @(negedge clk);
    check("fl_next_frame", m_data, mk_frame(8'hB0, 16));
`else
    check("nofl_no_frame", m_valid, 1'b0);
    @(posedge clk); #1;
    for (int i = 5; i < 16; i++) send(DW'(8'hA1 + i), 1'b0);
    @(negedge clk);
    check("nofl_m_valid", m_valid, 1'b1);
    check("nofl_m_count", m_count, 5'd16);
    check("nofl_m_data", m_data, mk_frame(8'hA1, 16));
`endif
    idle(3);

    // Backpressure: output frame plus full collector, then release
    m_ready = 1'b0;
    for (int i = 0; i < 32; i++) send(DW'(8'h30 + i), 1'b0);
    @(negedge clk);
    check("bp_s_ready_low", s_ready, 1'b0);
    check("bp_m_valid", m_valid, 1'b1);
    check("bp_hold_data", m_data, mk_frame(8'h30, 16));
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = 8'h50;
    repeat (3) begin
      @(negedge clk);
      check("bp_s_ready_held", s_ready, 1'b0);
      check("bp_data_stable", m_data, mk_frame(8'h30, 16));
      check("bp_count_stable", m_count, 5'd16);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_frame2_valid", m_valid, 1'b1);
    check("bp_frame2_data", m_data, mk_frame(8'h40, 16));
    check("bp_s_ready_back", s_ready, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) send(DW'(8'h50 + i), 1'b0);
    @(negedge clk);
    check("bp_frame3_data", m_data, mk_frame(8'h50, 16));
    idle(3);

    // Reset with a pending frame and a partial collector
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(DW'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 7; i++) send(DW'(8'hD0 + i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_s_ready", s_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_m_data", m_data, '0);
    check("mid_rst_m_count", m_count, '0);
    sb_q.delete();
    model_coll = '0;
    model_idx  = 0;
    @(posedge clk); #1;
    rst     = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(DW'(8'hE0 + i), 1'b0);
    @(negedge clk);
    check("post_rst_frame", m_data, mk_frame(8'hE0, 16));
    check("post_rst_count", m_count, 5'd16);
    idle(3);
    check("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
